// File: rtl/operand_select_if.sv
// Handshake bundle for the operand select stage.
// The slave side is the stage; the master side feeds and drains it.
interface operand_select_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [SELW-1:0]      in_sel;
  logic                 in_zero;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_sel;

  modport slave (
    input  in_data, in_sel, in_zero, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel
  );

  modport master (
    output in_data, in_sel, in_zero, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel
  );
endinterface

// File: rtl/operand_select_stage.sv
// Channel select / force-zero stage with a head+skid buffer.
// in_ready is registered so it never depends on out_ready.
module operand_select_stage #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input logic             clk,
  input logic             rst,
  operand_select_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [31:0]      sel_ext;
  logic             sel_bad;
  logic [WIDTH-1:0] chan;
  logic [WIDTH-1:0] result;
  logic             in_xfer;
  logic             out_xfer;

  assign bus.in_ready  = rdy_q;
  assign bus.out_data  = head_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.err_sel   = err_q;

  assign in_xfer  = bus.in_valid && rdy_q;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // Loop mux keeps out-of-range indices from slicing past in_data.
  always_comb begin
    sel_ext = 32'(bus.in_sel);
    sel_bad = (sel_ext >= 32'(NCH));
    chan    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_ext == 32'(k)) begin
        chan = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
    result = (bus.in_zero || sel_bad) ? '0 : chan;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d  = result;
          state_d = HALF;
        end
      end
      HALF: begin
        unique case (1'b1)
          in_xfer && out_xfer: begin
            head_d = result;
          end
          in_xfer && !out_xfer: begin
            skid_d  = result;
            state_d = FULL;
          end
          !in_xfer && out_xfer: begin
            head_d  = '0;
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          head_d  = skid_q;
          skid_d  = '0;
          state_d = HALF;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        skid_d  = '0;
      end
    endcase
    rdy_d = (state_d != FULL);
    err_d = err_q || (in_xfer && sel_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed bench for operand_select_stage.
// Vector table plus hand sequences for stalls, streaming and reset.
module tb_operand_select_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  operand_select_if #(.WIDTH(32), .NCH(4), .SELW(2)) a();
  operand_select_if #(.WIDTH(32), .NCH(3), .SELW(2)) b();

  operand_select_stage #(.WIDTH(32), .NCH(4), .SELW(2)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a.slave)
  );

  operand_select_stage #(.WIDTH(32), .NCH(3), .SELW(2)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        zero;
    logic        valid;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic        err;
  } vec_t;

  vec_t tv[11];

  int nchk = 0;
  int nerr = 0;

  logic [31:0] src[$];
  logic [31:0] got[$];
  int idx;
  int sel_s;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a();
    logic acc;
    logic oacc;
    logic [31:0] od;
    logic [127:0] d;
    d = '0;
    a.in_valid = (idx < src.size());
    a.in_sel = 2'(sel_s);
    a.in_zero = 1'b0;
    if (idx < src.size()) d[sel_s*32 +: 32] = src[idx];
    a.in_data = d;
    acc = a.in_valid && a.in_ready;
    oacc = a.out_valid && a.out_ready;
    od = a.out_data;
    tick();
    if (acc) idx++;
    if (oacc) got.push_back(od);
  endtask

  initial begin
    int irbad;
    int ordbad;
    int errdrop;
    int seen;

    tv[0]  = '{2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    tv[1]  = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tv[2]  = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0};
    tv[3]  = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0};
    tv[4]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0};
    tv[5]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b0};
    tv[6]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tv[7]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tv[8]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0};
    tv[9]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0};
    tv[10] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1;
    a.in_data = '0;
    a.in_sel = '0;
    a.in_zero = 1'b0;
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    b.in_data = '0;
    b.in_sel = '0;
    b.in_zero = 1'b0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;

    #12;
    chk("rst_ov", a.out_valid, 0);
    chk("rst_od", a.out_data, 0);
    chk("rst_ir", a.in_ready, 0);
    chk("rst_err", a.err_sel, 0);

    // First edge after release only raises in_ready.
    rst = 1'b0;
    a.in_data = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    a.in_sel = 2'd2;
    a.in_valid = 1'b1;
    tick();
    chk("rel_ir", a.in_ready, 1);
    chk("rel_ov", a.out_valid, 0);

    for (int i = 0; i < 11; i++) begin
      a.in_sel = tv[i].sel;
      a.in_zero = tv[i].zero;
      a.in_valid = tv[i].valid;
      a.out_ready = tv[i].ordy;
      tick();
      chk($sformatf("v%0d_ov", i), a.out_valid, tv[i].ov);
      chk($sformatf("v%0d_od", i), a.out_data, tv[i].od);
      chk($sformatf("v%0d_ir", i), a.in_ready, tv[i].ir);
      chk($sformatf("v%0d_err", i), a.err_sel, tv[i].err);
    end

    // Stall then drain: 1,2 fill the buffer, 3,4 follow without gaps.
    src = '{32'd1, 32'd2, 32'd3, 32'd4};
    got.delete();
    idx = 0;
    sel_s = 0;
    a.out_ready = 1'b0;
    step_a();
    step_a();
    chk("stall_ir", a.in_ready, 0);
    chk("stall_od", a.out_data, 1);
    step_a();
    chk("stall_hold", a.out_data, 1);
    chk("stall_acc", idx, 2);
    a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step_a();
    chk("drain_cnt", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("drain_%0d", i), got[i], i + 1);
    chk("drain_empty", a.out_valid, 0);

    // 100 back-to-back beats.
    src.delete();
    for (int i = 0; i < 100; i++) src.push_back(32'(100 + i));
    got.delete();
    idx = 0;
    sel_s = 1;
    irbad = 0;
    ordbad = 0;
    for (int i = 0; i < 101; i++) begin
      if (!a.in_ready) irbad++;
      step_a();
    end
    chk("bb_cnt", got.size(), 100);
    chk("bb_acc", idx, 100);
    chk("bb_ir", irbad, 0);
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== 32'(100 + i)) ordbad++;
    chk("bb_order", ordbad, 0);

    // NCH=3: a refused beat with bad select must not flag.
    b.in_data = {32'h0, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    b.out_ready = 1'b0;
    b.in_sel = 2'd0;
    b.in_valid = 1'b1;
    tick();
    tick();
    chk("b_full_ir", b.in_ready, 0);
    b.in_sel = 2'd3;
    tick();
    chk("b_refused_err", b.err_sel, 0);
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    tick();
    tick();
    chk("b_empty", b.out_valid, 0);
    b.in_sel = 2'd3;
    b.in_valid = 1'b1;
    tick();
    chk("b_bad_ov", b.out_valid, 1);
    chk("b_bad_od", b.out_data, 0);
    chk("b_bad_err", b.err_sel, 1);
    errdrop = 0;
    ordbad = 0;
    for (int i = 0; i < 10; i++) begin
      b.in_sel = 2'(i % 3);
      tick();
      if (b.err_sel !== 1'b1) errdrop++;
      if (b.out_data !== 32'hCCCC0000 + 32'(i % 3)) ordbad++;
    end
    chk("b_err_sticky", errdrop, 0);
    chk("b_legal_data", ordbad, 0);
    b.in_valid = 1'b0;

    // Async reset while FULL discards both held beats.
    src = '{32'hA, 32'hB};
    got.delete();
    idx = 0;
    sel_s = 0;
    a.out_ready = 1'b0;
    step_a();
    step_a();
    chk("ar_full_ir", a.in_ready, 0);
    chk("ar_full_ov", a.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ov", a.out_valid, 0);
    chk("ar_ir", a.in_ready, 0);
    chk("ar_od", a.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a.out_valid || a.out_data == 32'hA || a.out_data == 32'hB)
        seen++;
    end
    chk("ar_discard", seen, 0);
    chk("ar_ir_back", a.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
